fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the control unit. Holds the PC, issues
//  requests to instruction memory (variable latency, ready handshake) and drives the
//  registered IF/ID pair instr/instr_valid into decode. Handles decode stall via a
//  1-entry skid buffer, and branch redirect/flush. An invalid slot always presents 16'h0000 (NOP).
// PARAMETERS
//  PC_WIDTH   8      width of PC and imem_addr; PC wraps modulo 2**PC_WIDTH
//  RESET_PC   0      PC value loaded on reset
// PORTS
//  clk            in   1         single clock, all state on rising edge
//  rst            in   1         synchronous, active-high reset
//  stall          in   1         decode cannot accept; hold instr/instr_valid/pc_out
//  branch_taken   in   1         redirect request (single-cycle pulse)
//  branch_target  in   PC_WIDTH  new PC when branch_taken=1
//  imem_req       out  1         request to instruction memory
//  imem_addr      out  PC_WIDTH  fetch address; stable while imem_req=1
//  imem_ready     in   1         response valid; may arrive in the same cycle as imem_req
//  imem_rdata     in   16        instruction word, valid when imem_ready=1
//  instr          out  16        instruction to decode; 16'h0000 whenever instr_valid=0
//  instr_valid    out  1         instr holds a real fetched instruction
//  pc_out         out  PC_WIDTH  address of instr
//  halted         out  1         fetch stopped on HALT (tied 0 without FETCH_HALT_EN)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, imem_req=0, instr=16'h0000, instr_valid=0, pc_out=0,
//    halted=0, skid empty, drop flag clear. Reset mid-transaction abandons the request silently.
//  - FSM: IDLE -> REQ (one cycle after reset release). REQ: imem_req=!skid_valid, imem_addr=pc.
//    DROP: imem_req held (same addr) until imem_ready, response discarded, then -> REQ.
//    HALT: imem_req=0, terminal until reset.
//  - Accept: imem_req&&imem_ready -> pc<=pc+1 (wrap). Data goes to output regs if
//    (!instr_valid || !stall) && !skid_valid, else into skid (instr, pc).
//  - Output advance when stall=0: take skid if valid (skid cleared), else same-cycle
//    response, else bubble (instr_valid<=0, instr<=0). stall=1: outputs hold exactly.
//  - Once imem_req=1, it is never withdrawn before imem_ready (except rst/branch to DROP).
//  - Latency: zero-wait memory -> instr_valid one cycle after the request; throughput 1/cycle.
//  - branch_taken (priority over stall and responses): pc<=branch_target; instr_valid<=0,
//    instr<=0; skid cleared. If a request is outstanding and not readied this cycle,
//    -> DROP; else -> REQ issuing branch_target next cycle. Same-cycle response discarded.
//  - Branch in DROP: update pc to newest target, stay in DROP.
//  - Branch while halted (HALT): ignored.
// CONFIGURATION
//  FETCH_HALT_EN defined: accepted word with instr[15:12]==4'b1111 is delivered as
//   normal, then -> HALT, halted<=1 the cycle after acceptance; no further requests.
//   A branch in the same cycle wins (word discarded, no halt).
//  FETCH_HALT_EN undefined: opcode 4'b1111 is fetched like any other word; halted=0 always.
// TESTING
//  1 rst=1 3 cycles, release, mem ready same cycle -> imem_addr 0,1,2..; instr_valid from
//    2nd cycle after release; pc_out 0,1,2 with matching words.
//  2 mem latency 3 cycles -> one request per 3 cycles, imem_addr stable while waiting,
//    instr_valid pulses 1 cycle each, instr=0 between.
//  3 stall=1 for 4 cycles while response in flight -> outputs frozen, word lands in skid,
//    imem_req=0 while skid full; stall=0 -> skid word next, no loss/duplication.
//  4 branch_taken, target 8'h40, with request outstanding (latency 2) -> instr_valid=0
//    next cycle, stale word dropped, next imem_addr=8'h40, pc_out=8'h40 on delivery.
//  5 PC_WIDTH=8, pc=8'hFF -> next fetch addr 8'h00 (wrap).
//  6 FETCH_HALT_EN: word 16'hF000 at addr 3 -> delivered with pc_out=3, halted=1 next
//    cycle, imem_req=0 forever; without macro fetch continues to addr 4.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/ready handshake, IF/ID output regs, 1-entry skid, branch flush.
// Optional HALT-opcode stop is enabled by defining FETCH_HALT_EN.
module fetch_unit #(
  parameter int unsigned           PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         instr,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                halted
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HALT} state_t;

  state_t              state, next_state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] drop_addr;
  logic                skid_valid;
  logic [15:0]         skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;
  logic                accept;
  logic                branch_live;
  logic                advance;
  logic                halt_hit;

  // While draining an abandoned request the address must stay on the old PC,
  // even if further branches move pc on.
  assign imem_addr   = (state == S_DROP) ? drop_addr : pc;
  assign branch_live = branch_taken && (state != S_HALT);
  assign accept      = (state == S_REQ) && imem_req && imem_ready && !branch_taken;
  assign advance     = !stall || !instr_valid;

`ifdef FETCH_HALT_EN
  assign halt_hit = accept && (imem_rdata[15:12] == 4'b1111);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    imem_req   = 1'b0;
    next_state = state;
    case (state)
      S_IDLE: next_state = S_REQ;
      S_REQ: begin
        imem_req = !skid_valid;
        if (branch_taken)
          next_state = (!skid_valid && !imem_ready) ? S_DROP : S_REQ;
        else if (halt_hit)
          next_state = S_HALT;
      end
      S_DROP: begin
        imem_req = 1'b1;
        if (imem_ready)
          next_state = S_REQ;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      drop_addr   <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_out      <= '0;
    end else begin
      state <= next_state;

      if (branch_live)
        pc <= branch_target;
      else if (accept)
        pc <= pc + PC_WIDTH'(1);

      if ((state == S_REQ) && (next_state == S_DROP))
        drop_addr <= pc;

      if (branch_live) begin
        instr       <= '0;
        instr_valid <= 1'b0;
        skid_valid  <= 1'b0;
      end else if (advance) begin
        if (skid_valid) begin
          instr       <= skid_instr;
          pc_out      <= skid_pc;
          instr_valid <= 1'b1;
          skid_valid  <= 1'b0;
        end else if (accept) begin
          instr       <= imem_rdata;
          pc_out      <= pc;
          instr_valid <= 1'b1;
        end else begin
          instr       <= '0;
          instr_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if (halt_hit)
      halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a wait-state programmable memory responder.
// Build with FETCH_HALT_EN defined to exercise the HALT path.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;

  logic [7:0]  mem_wait;
  logic [7:0]  wait_cnt;
  logic        halt_on;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
  );

  // Memory answers after mem_wait stalled cycles; mem_wait=0 answers in the request cycle.
  always @(posedge clk) begin
    if (rst || (imem_req && imem_ready)) wait_cnt <= 8'd0;
    else if (imem_req)                   wait_cnt <= wait_cnt + 8'd1;
  end
  assign imem_ready = imem_req && (wait_cnt >= mem_wait);
  assign imem_rdata = (halt_on && imem_addr == 8'd3) ? 16'hF000 : {8'h5A, imem_addr};

  function automatic logic [15:0] word(input int a);
    logic [7:0] a8;
    a8 = a[7:0];
    return {8'h5A, a8};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    mem_wait = 8'd0; halt_on = 1'b0;

    // 1: reset, then zero-wait streaming
    repeat (3) cyc();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    cyc();
    check("idle_req", 32'(imem_req), 32'd1);
    check("idle_addr", 32'(imem_addr), 32'd0);
    check("idle_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("s1_valid", 32'(instr_valid), 32'd1);
      check("s1_instr", 32'(instr), 32'(word(i)));
      check("s1_pc_out", 32'(pc_out), 32'(i));
      check("s1_addr", 32'(imem_addr), 32'(i + 1));
    end

    // 2: two wait states -> one word per three cycles
    mem_wait = 8'd2;
    for (int k = 0; k < 2; k++) begin
      repeat (2) begin
        cyc();
        check("s2_bubble_valid", 32'(instr_valid), 32'd0);
        check("s2_bubble_instr", 32'(instr), 32'd0);
        check("s2_req_held", 32'(imem_req), 32'd1);
        check("s2_addr_held", 32'(imem_addr), 32'(4 + k));
      end
      cyc();
      check("s2_valid", 32'(instr_valid), 32'd1);
      check("s2_instr", 32'(instr), 32'(word(4 + k)));
      check("s2_pc_out", 32'(pc_out), 32'(4 + k));
    end

    // 3: stall while addr 6 is in flight
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cyc();
      check("s3_hold_valid", 32'(instr_valid), 32'd1);
      check("s3_hold_instr", 32'(instr), 32'(word(5)));
      check("s3_hold_pc", 32'(pc_out), 32'd5);
      check("s3_req", 32'(imem_req), (s < 2) ? 32'd1 : 32'd0);
    end
    stall = 1'b0;
    cyc();
    check("s3_skid_instr", 32'(instr), 32'(word(6)));
    check("s3_skid_pc", 32'(pc_out), 32'd6);
    check("s3_next_addr", 32'(imem_addr), 32'd7);
    repeat (2) begin
      cyc();
      check("s3_bubble", 32'(instr_valid), 32'd0);
    end
    cyc();
    check("s3_after_instr", 32'(instr), 32'(word(7)));
    check("s3_after_pc", 32'(pc_out), 32'd7);

    // 4: branch to 0x40 with addr 8 outstanding
    mem_wait = 8'd1;
    branch_taken = 1'b1; branch_target = 8'h40;
    cyc();
    branch_taken = 1'b0;
    check("s4_flush_valid", 32'(instr_valid), 32'd0);
    check("s4_flush_instr", 32'(instr), 32'd0);
    check("s4_drop_req", 32'(imem_req), 32'd1);
    check("s4_drop_addr", 32'(imem_addr), 32'h08);
    cyc();
    check("s4_dropped", 32'(instr_valid), 32'd0);
    check("s4_target_addr", 32'(imem_addr), 32'h40);
    cyc();
    check("s4_wait_valid", 32'(instr_valid), 32'd0);
    check("s4_wait_addr", 32'(imem_addr), 32'h40);
    cyc();
    check("s4_valid", 32'(instr_valid), 32'd1);
    check("s4_instr", 32'(instr), 32'(word(8'h40)));
    check("s4_pc_out", 32'(pc_out), 32'h40);

    // 5: branch with same-cycle response discarded, then PC wrap
    mem_wait = 8'd0;
    branch_taken = 1'b1; branch_target = 8'hFE;
    cyc();
    branch_taken = 1'b0;
    check("s5_flush_valid", 32'(instr_valid), 32'd0);
    check("s5_addr_fe", 32'(imem_addr), 32'hFE);
    cyc();
    check("s5_pc_fe", 32'(pc_out), 32'hFE);
    check("s5_addr_ff", 32'(imem_addr), 32'hFF);
    cyc();
    check("s5_pc_ff", 32'(pc_out), 32'hFF);
    check("s5_addr_wrap", 32'(imem_addr), 32'h00);
    cyc();
    check("s5_instr_00", 32'(instr), 32'(word(0)));
    check("s5_pc_00", 32'(pc_out), 32'h00);

    // 6: 0xF000 at addr 3
    halt_on = 1'b1;
    branch_taken = 1'b1; branch_target = 8'h02;
    cyc();
    branch_taken = 1'b0;
    check("s6_addr2", 32'(imem_addr), 32'h02);
    cyc();
    check("s6_pc2", 32'(pc_out), 32'h02);
    cyc();
    check("s6_halt_word", 32'(instr), 32'hF000);
    check("s6_halt_pc", 32'(pc_out), 32'h03);
    check("s6_halt_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_HALT_EN
    check("s6_halted", 32'(halted), 32'd1);
    check("s6_req_off", 32'(imem_req), 32'd0);
    branch_taken = 1'b1; branch_target = 8'h10;
    cyc();
    branch_taken = 1'b0;
    check("s6_h_req", 32'(imem_req), 32'd0);
    check("s6_h_halted", 32'(halted), 32'd1);
    check("s6_h_valid", 32'(instr_valid), 32'd0);
    cyc();
    check("s6_h_req2", 32'(imem_req), 32'd0);
    check("s6_h_halted2", 32'(halted), 32'd1);
`else
    check("s6_not_halted", 32'(halted), 32'd0);
    check("s6_req_on", 32'(imem_req), 32'd1);
    check("s6_addr4", 32'(imem_addr), 32'h04);
    cyc();
    check("s6_instr4", 32'(instr), 32'(word(4)));
    check("s6_pc4", 32'(pc_out), 32'h04);
`endif

    // reset from the middle of operation
    rst = 1'b1;
    cyc();
    check("rst2_valid", 32'(instr_valid), 32'd0);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_req", 32'(imem_req), 32'd0);
    check("rst2_pc_out", 32'(pc_out), 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
